pll_reconfig_ctrl: RTL and testbench

Run-time controller for one Gowin rPLL used in dynamic mode (DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true", DYN_DA_EN = "true").
- Selects one of NUM_PROFILES divider/phase profiles and drives the PLL IDSEL/FBDSEL/ODSEL/PSDA pins.
- Sequences PLL reset, debounces LOCK, retries on lock timeout and recovers from lock loss.
- Sits beside the PLL in the board reference-clock domain (27 MHz). Downstream logic (DDR3 PHY clocking) gates on `locked`.

---
 rtl/pll_ctrl_pkg.sv | 21 ++
 rtl/pll_lock_filter.sv | 59 +++++
 rtl/pll_reconfig_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
// Shared definitions for the rPLL reconfiguration controller:
//   - controller state encoding
//   - width of one profile word and the bit offsets of its fields
//     (idsel[5:0] | fbdsel[5:0] | odsel[5:0] | psda[3:0], MSB to LSB)
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_ASSERT = 2'd0,
    WAIT_LOCK    = 2'd1,
    LOCKED       = 2'd2,
    FAIL         = 2'd3
  } pll_state_e;

  localparam int PROFILE_W  = 22;
  localparam int IDSEL_LSB  = 16;
  localparam int FBDSEL_LSB = 10;
  localparam int ODSEL_LSB  = 4;
  localparam int PSDA_LSB   = 0;

endpackage

// File: rtl/pll_lock_filter.sv
// pll_lock_filter
// Brings the raw rPLL LOCK pin into the clk domain and qualifies it.
// Ports:
//   clk, rst_n : reference clock, async active-low reset
//   clr        : synchronous clear, held while the PLL is being reset so that
//                a LOCK level left over from the previous attempt is forgotten
//   lock_raw   : raw LOCK pin, asynchronous to clk
//   lk_s       : synchronised LOCK
//   stable     : lk_s has been high for LOCK_STABLE_CYCLES consecutive cycles
module pll_lock_filter #(
  parameter int LOCK_STABLE_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic lock_raw,
  output logic lk_s,
  output logic stable
);

  localparam int CNT_W = (LOCK_STABLE_CYCLES < 1) ? 1 : $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_STABLE_CYCLES);

  logic             meta_r;
  logic             sync_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-flop synchroniser for the asynchronous LOCK pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else if (clr) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= lock_raw;
      sync_r <= meta_r;
    end
  end

  // Consecutive-high counter; saturates at the stability threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr || !sync_r) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign lk_s   = sync_r;
  // Gated with sync_r so a drop is never reported as stable for one cycle.
  assign stable = sync_r && (cnt_r == CNT_MAX);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
// Run-time controller for one Gowin rPLL in dynamic mode. Selects a
// divider/phase profile, sequences the PLL reset, qualifies LOCK, retries on
// lock timeout and recovers from lock loss. Single clock domain (clk).
// Ports:
//   clk, rst_n                    : reference clock, async active-low reset
//   req_valid/req_profile/req_ready : profile-change handshake
//   phase_inc, phase_dec          : single-cycle PSDA step pulses (LOCKED only)
//   pll_lock                      : raw LOCK pin from the rPLL
//   pll_reset, pll_idsel, pll_fbdsel, pll_odsel, pll_psda : rPLL control pins
//   cur_profile                   : active profile index
//   locked, busy, error           : status
//   bad_req                       : pulse on an accepted out-of-range request
//   lost_lock_cnt                 : saturating count of lock-loss events
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_PROFILES = 4,
  parameter int PRF_W        = 2,
  parameter logic [PROFILE_W*NUM_PROFILES-1:0] PROFILE_TABLE = {NUM_PROFILES{22'h0}},
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [PRF_W-1:0] req_profile,
  output logic             req_ready,
  input  logic             phase_inc,
  input  logic             phase_dec,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [5:0]       pll_idsel,
  output logic [5:0]       pll_fbdsel,
  output logic [5:0]       pll_odsel,
  output logic [3:0]       pll_psda,
  output logic [PRF_W-1:0] cur_profile,
  output logic             locked,
  output logic             busy,
  output logic             error,
  output logic             bad_req,
  output logic [7:0]       lost_lock_cnt
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int TO_W  = (LOCK_TIMEOUT_CYCLES < 2) ? 1 : $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [RST_W-1:0]     RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0]     RTY_MAX   = RTY_W'(MAX_RETRIES);
  localparam logic [PROFILE_W-1:0] PROFILE_0 = PROFILE_TABLE[PROFILE_W-1:0];

  pll_state_e           state_r;
  logic [RST_W-1:0]     rst_cnt_r;
  logic [TO_W-1:0]      to_cnt_r;
  logic [RTY_W-1:0]     retry_r;

  logic                 lk_s;
  logic                 stable_s;
  logic                 filt_clr_s;
  logic                 req_accept_s;
  logic                 req_in_range_s;
  logic [PROFILE_W-1:0] req_word_s;

  function automatic logic [PROFILE_W-1:0] profile_at(input logic [PRF_W-1:0] idx);
    return PROFILE_TABLE[32'(idx)*PROFILE_W +: PROFILE_W];
  endfunction

  assign filt_clr_s = (state_r == RESET_ASSERT);

  pll_lock_filter #(
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (filt_clr_s),
    .lock_raw (pll_lock),
    .lk_s     (lk_s),
    .stable   (stable_s)
  );

  // Request decode: acceptance, range check and the addressed profile word.
  always_comb begin
    req_accept_s   = req_valid && req_ready;
    req_in_range_s = (32'(req_profile) < NUM_PROFILES);
    if (req_in_range_s) begin
      req_word_s = profile_at(req_profile);
    end else begin
      // Never index past the table; the word is unused for a bad request.
      req_word_s = profile_at(PRF_W'(0));
    end
  end

  // Controller state machine; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RESET_ASSERT;
      rst_cnt_r     <= '0;
      to_cnt_r      <= '0;
      retry_r       <= '0;
      pll_reset     <= 1'b1;
      pll_idsel     <= PROFILE_0[IDSEL_LSB +: 6];
      pll_fbdsel    <= PROFILE_0[FBDSEL_LSB +: 6];
      pll_odsel     <= PROFILE_0[ODSEL_LSB +: 6];
      pll_psda      <= PROFILE_0[PSDA_LSB +: 4];
      cur_profile   <= '0;
      locked        <= 1'b0;
      busy          <= 1'b1;
      error         <= 1'b0;
      bad_req       <= 1'b0;
      lost_lock_cnt <= 8'd0;
      req_ready     <= 1'b0;
    end else begin
      bad_req <= 1'b0;
      case (state_r)
        RESET_ASSERT: begin
          if (rst_cnt_r == RST_LAST) begin
            state_r   <= WAIT_LOCK;
            pll_reset <= 1'b0;
            to_cnt_r  <= '0;
          end else begin
            rst_cnt_r <= rst_cnt_r + RST_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (stable_s) begin
            state_r   <= LOCKED;
            locked    <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            retry_r   <= '0;
          end else if (to_cnt_r == TO_LAST) begin
            if (retry_r < RTY_MAX) begin
              retry_r   <= retry_r + RTY_W'(1);
              state_r   <= RESET_ASSERT;
              rst_cnt_r <= '0;
              pll_reset <= 1'b1;
            end else begin
              state_r   <= FAIL;
              pll_reset <= 1'b1;
              error     <= 1'b1;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end

        LOCKED: begin
          if (req_accept_s && req_in_range_s) begin
            // New profile: even the active one goes through a full reset.
            pll_idsel   <= req_word_s[IDSEL_LSB +: 6];
            pll_fbdsel  <= req_word_s[FBDSEL_LSB +: 6];
            pll_odsel   <= req_word_s[ODSEL_LSB +: 6];
            pll_psda    <= req_word_s[PSDA_LSB +: 4];
            cur_profile <= req_profile;
            state_r     <= RESET_ASSERT;
            rst_cnt_r   <= '0;
            retry_r     <= '0;
            pll_reset   <= 1'b1;
            locked      <= 1'b0;
            busy        <= 1'b1;
            error       <= 1'b0;
            req_ready   <= 1'b0;
          end else if (!lk_s) begin
            if (lost_lock_cnt != 8'hFF) begin
              lost_lock_cnt <= lost_lock_cnt + 8'd1;
            end else begin
              lost_lock_cnt <= lost_lock_cnt;
            end
            bad_req   <= req_accept_s;
            state_r   <= RESET_ASSERT;
            rst_cnt_r <= '0;
            pll_reset <= 1'b1;
            locked    <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else if (req_accept_s) begin
            // Out-of-range request: handshake completes, nothing else moves.
            bad_req <= 1'b1;
          end else if (phase_inc && !phase_dec) begin
            pll_psda <= pll_psda + 4'd1;
          end else if (phase_dec && !phase_inc) begin
            pll_psda <= pll_psda - 4'd1;
          end else begin
            pll_psda <= pll_psda;
          end
        end

        FAIL: begin
          if (req_accept_s && req_in_range_s) begin
            pll_idsel   <= req_word_s[IDSEL_LSB +: 6];
            pll_fbdsel  <= req_word_s[FBDSEL_LSB +: 6];
            pll_odsel   <= req_word_s[ODSEL_LSB +: 6];
            pll_psda    <= req_word_s[PSDA_LSB +: 4];
            cur_profile <= req_profile;
            state_r     <= RESET_ASSERT;
            rst_cnt_r   <= '0;
            retry_r     <= '0;
            pll_reset   <= 1'b1;
            locked      <= 1'b0;
            busy        <= 1'b1;
            error       <= 1'b0;
            req_ready   <= 1'b0;
          end else if (req_accept_s) begin
            bad_req <= 1'b1;
          end else begin
            pll_reset <= 1'b1;
          end
        end

        default: begin
          state_r   <= RESET_ASSERT;
          rst_cnt_r <= '0;
          pll_reset <= 1'b1;
          locked    <= 1'b0;
          busy      <= 1'b1;
          error     <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl
// Self-checking bench for pll_reconfig_ctrl: power-up, profile switch, phase
// stepping and bad requests (vector tables), lock loss, timeout/FAIL recovery
// and asynchronous reset. PRF_W is widened to 3 so that an out-of-range index
// (5) can be presented to a four-profile instance.
module tb_pll_reconfig_ctrl;

  localparam logic [21:0] P0 = {6'd1, 6'd10, 6'd8,  4'd0};
  localparam logic [21:0] P1 = {6'd2, 6'd20, 6'd4,  4'd3};
  localparam logic [21:0] P2 = {6'd3, 6'd33, 6'd2,  4'd14};
  localparam logic [21:0] P3 = {6'd5, 6'd40, 6'd16, 4'd7};
  localparam logic [87:0] TABLE = {P3, P2, P1, P0};

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_profile;
  logic       req_ready;
  logic       phase_inc;
  logic       phase_dec;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic [3:0] pll_psda;
  logic [2:0] cur_profile;
  logic       locked;
  logic       busy;
  logic       error;
  logic       bad_req;
  logic [7:0] lost_lock_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rv;
    logic [2:0] rp;
    logic       inc;
    logic       dec;
    logic       lk;
    logic       e_rst;
    logic       e_lkd;
    logic [3:0] e_psda;
    logic [2:0] e_prof;
    logic [5:0] e_idsel;
    logic       e_bad;
    logic       e_rdy;
    logic       e_err;
  } vec_t;

  vec_t sb_q[$];
  vec_t ph_tab[11];
  vec_t fl_tab[5];

  pll_reconfig_ctrl #(
    .NUM_PROFILES        (4),
    .PRF_W               (3),
    .PROFILE_TABLE       (TABLE),
    .RST_CYCLES          (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (100),
    .MAX_RETRIES         (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_profile   (req_profile),
    .req_ready     (req_ready),
    .phase_inc     (phase_inc),
    .phase_dec     (phase_dec),
    .pll_lock      (pll_lock),
    .pll_reset     (pll_reset),
    .pll_idsel     (pll_idsel),
    .pll_fbdsel    (pll_fbdsel),
    .pll_odsel     (pll_odsel),
    .pll_psda      (pll_psda),
    .cur_profile   (cur_profile),
    .locked        (locked),
    .busy          (busy),
    .error         (error),
    .bad_req       (bad_req),
    .lost_lock_cnt (lost_lock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic rv, input logic [2:0] rp, input logic inc,
                              input logic dec, input logic lk, input logic e_rst,
                              input logic e_lkd, input logic [3:0] e_psda,
                              input logic [2:0] e_prof, input logic [5:0] e_idsel,
                              input logic e_bad, input logic e_rdy, input logic e_err);
    vec_t v;
    v.rv = rv; v.rp = rp; v.inc = inc; v.dec = dec; v.lk = lk;
    v.e_rst = e_rst; v.e_lkd = e_lkd; v.e_psda = e_psda; v.e_prof = e_prof;
    v.e_idsel = e_idsel; v.e_bad = e_bad; v.e_rdy = e_rdy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    req_valid   = v.rv;
    req_profile = v.rp;
    phase_inc   = v.inc;
    phase_dec   = v.dec;
    pll_lock    = v.lk;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, " pll_reset"},   32'(pll_reset),   32'(e.e_rst));
    chk({tag, " locked"},      32'(locked),      32'(e.e_lkd));
    chk({tag, " pll_psda"},    32'(pll_psda),    32'(e.e_psda));
    chk({tag, " cur_profile"}, 32'(cur_profile), 32'(e.e_prof));
    chk({tag, " pll_idsel"},   32'(pll_idsel),   32'(e.e_idsel));
    chk({tag, " bad_req"},     32'(bad_req),     32'(e.e_bad));
    chk({tag, " req_ready"},   32'(req_ready),   32'(e.e_rdy));
    chk({tag, " error"},       32'(error),       32'(e.e_err));
    req_valid = 1'b0;
    phase_inc = 1'b0;
    phase_dec = 1'b0;
  endtask

  task automatic wait_reset(input logic val, input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (pll_reset !== val && n < bound);
  endtask

  task automatic wait_locked(input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (locked !== 1'b1 && n < bound);
  endtask

  // Reset pulse of 4 cycles, then locked 2 + 8 cycles (+-1) after it falls.
  task automatic measure_relock(input string tag);
    int n;
    wait_reset(1'b0, 40, n);
    chk({tag, " reset pulse length"}, 32'(n), 32'd4);
    wait_locked(60, n);
    chk_range({tag, " lock latency"}, n, 9, 11);
    chk({tag, " locked"},    32'(locked),    32'd1);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " pll_reset"}, 32'(pll_reset), 32'd0);
  endtask

  initial begin
    int n;
    int h;
    int l;

    // Phase / bad-request table: profile 2 locked, psda starts at 14.
    ph_tab[0]  = mk(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    ph_tab[1]  = mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    ph_tab[2]  = mk(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    ph_tab[3]  = mk(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1,  3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    ph_tab[4]  = mk(1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    ph_tab[5]  = mk(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    ph_tab[6]  = mk(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    ph_tab[7]  = mk(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd14, 3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    ph_tab[8]  = mk(1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd14, 3'd2, 6'd3, 1'b1, 1'b1, 1'b0);
    ph_tab[9]  = mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd14, 3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    ph_tab[10] = mk(1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd14, 3'd2, 6'd3, 1'b0, 1'b0, 1'b0);

    // FAIL table: stuck in FAIL on profile 2, then recover onto profile 1.
    fl_tab[0] = mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd14, 3'd2, 6'd3, 1'b0, 1'b1, 1'b1);
    fl_tab[1] = mk(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd14, 3'd2, 6'd3, 1'b0, 1'b1, 1'b1);
    fl_tab[2] = mk(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd14, 3'd2, 6'd3, 1'b1, 1'b1, 1'b1);
    fl_tab[3] = mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd14, 3'd2, 6'd3, 1'b0, 1'b1, 1'b1);
    fl_tab[4] = mk(1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3,  3'd1, 6'd2, 1'b0, 1'b0, 1'b0);

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_profile = 3'd0;
    phase_inc   = 1'b0;
    phase_dec   = 1'b0;
    pll_lock    = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst pll_reset",     32'(pll_reset),     32'd1);
    chk("rst pll_idsel",     32'(pll_idsel),     32'd1);
    chk("rst pll_fbdsel",    32'(pll_fbdsel),    32'd10);
    chk("rst pll_odsel",     32'(pll_odsel),     32'd8);
    chk("rst pll_psda",      32'(pll_psda),      32'd0);
    chk("rst cur_profile",   32'(cur_profile),   32'd0);
    chk("rst locked",        32'(locked),        32'd0);
    chk("rst busy",          32'(busy),          32'd1);
    chk("rst error",         32'(error),         32'd0);
    chk("rst bad_req",       32'(bad_req),       32'd0);
    chk("rst lost_lock_cnt", 32'(lost_lock_cnt), 32'd0);
    chk("rst req_ready",     32'(req_ready),     32'd0);

    // Power-up with LOCK tied high.
    @(negedge clk);
    rst_n = 1'b1;
    measure_relock("powerup");
    chk("powerup pll_fbdsel", 32'(pll_fbdsel), 32'd10);
    chk("powerup pll_odsel",  32'(pll_odsel),  32'd8);
    chk("powerup pll_psda",   32'(pll_psda),   32'd0);

    // Profile switch to 2.
    step(mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd14, 3'd2, 6'd3, 1'b0, 1'b0, 1'b0), "switch");
    chk("switch pll_fbdsel", 32'(pll_fbdsel), 32'd33);
    chk("switch pll_odsel",  32'(pll_odsel),  32'd2);
    chk("switch busy",       32'(busy),       32'd1);
    measure_relock("switch relock");

    // Phase stepping and bad request; last row re-requests profile 2.
    for (int i = 0; i < 11; i++) begin
      step(ph_tab[i], $sformatf("phase[%0d]", i));
    end
    measure_relock("same-profile relock");

    // Lock loss for 3 cycles.
    @(negedge clk);
    pll_lock = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (locked !== 1'b0 && n < 3);
    chk("lockloss locked", 32'(locked), 32'd0);
    chk_range("lockloss latency", n, 1, 3);
    chk("lockloss lost_lock_cnt", 32'(lost_lock_cnt), 32'd1);
    chk("lockloss pll_reset", 32'(pll_reset), 32'd1);
    @(negedge clk);
    pll_lock = 1'b1;
    measure_relock("lockloss relock");
    chk("lockloss lost_lock_cnt after", 32'(lost_lock_cnt), 32'd1);

    // Timeout: LOCK held low -> three attempts, then FAIL.
    @(negedge clk);
    pll_lock = 1'b0;
    wait_reset(1'b1, 10, n);
    chk_range("timeout first reset", n, 1, 4);
    chk("timeout lost_lock_cnt", 32'(lost_lock_cnt), 32'd2);
    for (int a = 0; a < 3; a++) begin
      wait_reset(1'b0, 20, h);
      chk($sformatf("attempt%0d reset length", a), 32'(h), 32'd4);
      wait_reset(1'b1, 200, l);
      chk($sformatf("attempt%0d wait length", a), 32'(l), 32'd100);
      chk($sformatf("attempt%0d error", a), 32'(error), (a == 2) ? 32'd1 : 32'd0);
      chk($sformatf("attempt%0d busy", a),  32'(busy),  (a == 2) ? 32'd0 : 32'd1);
      chk($sformatf("attempt%0d req_ready", a), 32'(req_ready), (a == 2) ? 32'd1 : 32'd0);
    end

    // FAIL holds until a valid request, which restarts on profile 1.
    for (int i = 0; i < 5; i++) begin
      step(fl_tab[i], $sformatf("fail[%0d]", i));
    end
    chk("recover pll_fbdsel", 32'(pll_fbdsel), 32'd20);
    chk("recover pll_odsel",  32'(pll_odsel),  32'd4);
    measure_relock("recover relock");

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async pll_reset",     32'(pll_reset),     32'd1);
    chk("async locked",        32'(locked),        32'd0);
    chk("async cur_profile",   32'(cur_profile),   32'd0);
    chk("async pll_idsel",     32'(pll_idsel),     32'd1);
    chk("async pll_psda",      32'(pll_psda),      32'd0);
    chk("async lost_lock_cnt", 32'(lost_lock_cnt), 32'd0);
    chk("async busy",          32'(busy),          32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
